decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 197 +++++++++++++++++++
 tb/tb_decode_stage.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I/RV64I decode pipeline stage: registered field split, sign-extended immediate, format and legality.
// Define DECODE_SKID_EN for a two-entry skid buffer with registered in_ready; otherwise a single register.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);
  localparam logic IS_RV32 = (XLEN == 32);

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32    = 7'b0111011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  logic [2:0]      fmt;
  logic            illegal;
  entry_t          dec;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  // Immediates are assembled at 32 bits, then widened by replicating bit 31.
  always_comb begin
    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
    fmt   = 3'd1;
    case (op)
      OPC_STORE: begin
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        fmt   = 3'd2;
      end
      OPC_BRANCH: begin
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        fmt   = 3'd3;
      end
      OPC_JAL: begin
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        fmt   = 3'd5;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {in_instr[31:12], 12'b0};
        fmt   = 3'd4;
      end
      OPC_OP: begin
        imm32 = 32'b0;
        fmt   = 3'd0;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_imm_ext
    if (gi < 32) begin : g_low
      assign imm_ext[gi] = imm32[gi];
    end else begin : g_high
      assign imm_ext[gi] = imm32[31];
    end
  end

  always_comb begin
    illegal = 1'b0;
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: illegal = 1'b0;
      OPC_JALR:   illegal = (f3 != 3'b000);
      OPC_BRANCH: illegal = (f3 == 3'b010) || (f3 == 3'b011);
      OPC_LOAD:   illegal = (f3 == 3'b111) || (IS_RV32 && ((f3 == 3'b011) || (f3 == 3'b110)));
      OPC_STORE:  illegal = f3[2] || (IS_RV32 && (f3 == 3'b011));
      OPC_OP:     illegal = !((f7 == 7'b0000000) || (f7 == 7'b0100000)) ||
                            ((f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OP_IMM: begin
        // RV64 shift amounts are six bits wide, so bit 25 belongs to shamt there.
        if (f3 == 3'b001) begin
          illegal = IS_RV32 ? (in_instr[31:25] != 7'b0) : (in_instr[31:26] != 6'b0);
        end else if (f3 == 3'b101) begin
          illegal = IS_RV32 ? !((in_instr[31:25] == 7'b0) || (in_instr[31:25] == 7'b0100000))
                            : !((in_instr[31:26] == 6'b0) || (in_instr[31:26] == 6'b010000));
        end
      end
      OPC_OP_IMM32, OPC_OP_32: illegal = IS_RV32;
      default: illegal = 1'b1;
    endcase
    if (in_instr[1:0] != 2'b11) illegal = 1'b1;
  end

  assign dec = '{pc: in_pc, instr: in_instr, imm: imm_ext, fmt: fmt, illegal: illegal};

  entry_t main_reg;
  logic   main_valid_reg;
  logic   in_xfer;

  assign in_xfer = in_valid && in_ready;

`ifdef DECODE_SKID_EN
  entry_t skid_reg;
  logic   skid_valid_reg;
  logic   main_drain;

  assign in_ready   = !skid_valid_reg;
  assign main_drain = !main_valid_reg || out_ready;

  // Skid only fills while main is stalled, so it is never valid with main empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (main_drain) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (in_xfer) begin
        main_reg       <= dec;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_reg       <= dec;
      skid_valid_reg <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_reg       <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
    end else if (in_xfer) begin
      main_valid_reg <= 1'b1;
      main_reg       <= dec;
    end else if (out_ready) begin
      main_valid_reg <= 1'b0;
    end
  end
`endif

  assign out_valid   = main_valid_reg;
  assign out_pc      = main_reg.pc;
  assign out_opcode  = main_reg.instr[6:0];
  assign out_rd      = main_reg.instr[11:7];
  assign out_funct3  = main_reg.instr[14:12];
  assign out_rs1     = main_reg.instr[19:15];
  assign out_rs2     = main_reg.instr[24:20];
  assign out_funct7  = main_reg.instr[31:25];
  assign out_imm     = main_reg.imm;
  assign out_fmt     = main_reg.fmt;
  assign out_illegal = main_reg.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32 and an RV64 instance share one stimulus stream.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] pc32, imm32;
  logic [6:0]  opc32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32, fmt32;

  logic        in_ready64, out_valid64, ill64;
  logic [31:0] pc64;
  logic [63:0] imm64;
  logic [6:0]  opc64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64, fmt64;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid32), .out_ready(out_ready),
    .out_pc(pc32), .out_opcode(opc32), .out_rd(rd32), .out_funct3(f3_32), .out_rs1(rs1_32),
    .out_rs2(rs2_32), .out_funct7(f7_32), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );

  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(pc64), .out_opcode(opc64), .out_rd(rd64), .out_funct3(f3_64), .out_rs1(rs1_64),
    .out_rs2(rs2_64), .out_funct7(f7_64), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic        ill32;
    logic        ill64;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cycle[int];
  int   n_chk = 0;
  int   n_pass = 0;
  int   next_tag = 0;
  int   cyc = 0;
  bit   drv_done;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t get_vec(input int i);
    case (i)
      0:  return vec_t'{32'h00500093, 5'd1,  5'd0,  5'd5,  3'd1, 32'h00000005, 64'h5, 1'b0, 1'b0};
      1:  return vec_t'{32'hFE000EE3, 5'd29, 5'd0,  5'd0,  3'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0, 1'b0};
      2:  return vec_t'{32'h0020A423, 5'd8,  5'd1,  5'd2,  3'd2, 32'h00000008, 64'h8, 1'b0, 1'b0};
      3:  return vec_t'{32'h800002B7, 5'd5,  5'd0,  5'd0,  3'd4, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0, 1'b0};
      4:  return vec_t'{32'h00000000, 5'd0,  5'd0,  5'd0,  3'd1, 32'h00000000, 64'h0, 1'b1, 1'b1};
      5:  return vec_t'{32'h0000A063, 5'd0,  5'd1,  5'd0,  3'd3, 32'h00000000, 64'h0, 1'b1, 1'b1};
      6:  return vec_t'{32'h40001033, 5'd0,  5'd0,  5'd0,  3'd0, 32'h00000000, 64'h0, 1'b1, 1'b1};
      7:  return vec_t'{32'h0010009B, 5'd1,  5'd0,  5'd1,  3'd1, 32'h00000001, 64'h1, 1'b1, 1'b0};
      8:  return vec_t'{32'h02009093, 5'd1,  5'd1,  5'd0,  3'd1, 32'h00000020, 64'h20, 1'b1, 1'b0};
      9:  return vec_t'{32'h00003083, 5'd1,  5'd0,  5'd0,  3'd1, 32'h00000000, 64'h0, 1'b1, 1'b0};
      10: return vec_t'{32'h008000EF, 5'd1,  5'd0,  5'd8,  3'd5, 32'h00000008, 64'h8, 1'b0, 1'b0};
      11: return vec_t'{32'h00009067, 5'd0,  5'd1,  5'd0,  3'd1, 32'h00000000, 64'h0, 1'b1, 1'b1};
      12: return vec_t'{32'h402081B3, 5'd3,  5'd1,  5'd2,  3'd0, 32'h00000000, 64'h0, 1'b0, 1'b0};
      default: return vec_t'{32'hFFFFF117, 5'd2, 5'd31, 5'd31, 3'd4, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Holds in_valid until the stage is ready, then queues the expected result.
  task automatic send(input int vi, input logic [31:0] pc, output int tag);
    vec_t v;
    exp_t e;
    bit   ok;
    v = get_vec(vi);
    ok = 1'b0;
    tag = -1;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_pc    = pc;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready32) begin
        ok = 1'b1;
        e.v = v; e.pc = pc; e.tag = next_tag;
        tag = next_tag;
        next_tag++;
        exp_q.push_back(e);
        $display("send tag=%0d instr=%08h pc=%0h", tag, v.instr, pc);
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL send_timeout: instr %08h never accepted, required acceptance within 50 cycles", v.instr);
    end
  endtask

  // Monitor: every output transfer pops and checks one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (out_valid32 || out_valid64) && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got pc %0h, required no output", pc32);
        end else begin
          e = exp_q.pop_front();
          pop_cycle[e.tag] = cyc;
          $display("recv tag=%0d instr=%08h imm32=%08h imm64=%016h fmt=%0d ill=%0d/%0d",
                   e.tag, e.v.instr, imm32, imm64, fmt32, ill32, ill64);
          chk("valid32", {63'b0, out_valid32}, 64'd1);
          chk("valid64", {63'b0, out_valid64}, 64'd1);
          chk("pc32", {32'b0, pc32}, {32'b0, e.pc});
          chk("pc64", {32'b0, pc64}, {32'b0, e.pc});
          chk("fields32", {32'b0, f7_32, rs2_32, rs1_32, f3_32, rd32, opc32}, {32'b0, e.v.instr});
          chk("fields64", {32'b0, f7_64, rs2_64, rs1_64, f3_64, rd64, opc64}, {32'b0, e.v.instr});
          chk("rd", {59'b0, rd32}, {59'b0, e.v.rd});
          chk("rs1", {59'b0, rs1_32}, {59'b0, e.v.rs1});
          chk("rs2", {59'b0, rs2_32}, {59'b0, e.v.rs2});
          chk("fmt32", {61'b0, fmt32}, {61'b0, e.v.fmt});
          chk("fmt64", {61'b0, fmt64}, {61'b0, e.v.fmt});
          chk("imm32", {32'b0, imm32}, {32'b0, e.v.imm32});
          chk("imm64", imm64, e.v.imm64);
          chk("illegal32", {63'b0, ill32}, {63'b0, e.v.ill32});
          chk("illegal64", {63'b0, ill64}, {63'b0, e.v.ill64});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, ta, td, tf;
    vec_t va;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_valid32", {63'b0, out_valid32}, 64'd0);
    chk("rst_valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst_pc", {32'b0, pc32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_fields", {32'b0, f7_32, rs2_32, rs1_32, f3_32, rd32, opc32}, 64'd0);
    chk("rst_fmt_ill", {60'b0, fmt32, ill32}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready32}, 64'd1);
    @(posedge clk); #1;

    // Single instruction, one-cycle latency.
    send(0, 32'h100, t1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", {63'b0, out_valid32}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back branch then store must leave on consecutive cycles.
    send(1, 32'h104, t1);
    send(2, 32'h108, t2);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("no_bubble", 64'(pop_cycle[t2]), 64'(pop_cycle[t1] + 1));

    // Remaining directed vectors streamed back-to-back.
    for (int i = 3; i < 14; i++) send(i, 32'h200 + 32'(4 * i), t1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Stall: A held while B and C wait upstream.
    out_ready = 1'b0;
    va = get_vec(11);
    send(11, 32'h300, ta);
    drv_done = 1'b0;
    fork
      begin
        int tb_, tc_;
        send(12, 32'h304, tb_);
        send(13, 32'h308, tc_);
        in_valid = 1'b0;
        drv_done = 1'b1;
      end
    join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", {63'b0, out_valid32}, 64'd1);
      chk("stall_pc", {32'b0, pc32}, 64'h300);
      chk("stall_fields", {32'b0, f7_32, rs2_32, rs1_32, f3_32, rd32, opc32}, {32'b0, va.instr});
`ifdef DECODE_SKID_EN
      chk("stall_in_ready", {63'b0, in_ready32}, (k == 0) ? 64'd1 : 64'd0);
`else
      chk("stall_in_ready", {63'b0, in_ready32}, 64'd0);
`endif
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && !drv_done; t++) begin
      @(posedge clk); #1;
    end
    chk("stall_driver_done", {63'b0, drv_done}, 64'd1);
    repeat (4) @(posedge clk);
    #1;

    // Flush while an entry is presented and a new instruction is offered.
    out_ready = 1'b0;
    send(10, 32'h400, td);
    in_valid  = 1'b1;
    in_instr  = 32'h00000000;
    in_pc     = 32'h404;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {63'b0, in_ready32}, 64'd1);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid32", {63'b0, out_valid32}, 64'd0);
    chk("flush_valid64", {63'b0, out_valid64}, 64'd0);
    @(posedge clk); #1;
    send(0, 32'h408, tf);
    in_valid = 1'b0;

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
